id_ex_fwd: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use detection for the RV32I core. Captures decoded instruction fields at the clock edge and drives the `alu` operand inputs `A`, `B` and `ctrl`, substituting in-flight results from MEM and WB for stale register-file values. Detects load-use hazards, inserts a bubble, and signals decode to hold.

---
 rtl/id_ex_fwd.sv | 130 +++++++++++++
 tb/tb_id_ex_fwd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd.sv
// ID/EX pipeline register for the RV32I core: captures decoded fields, forwards MEM/WB
// results into the ALU operands and raises load_use so decode holds for one bubble.
module id_ex_fwd #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            mem_reg_write,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] mem_res,
    input  logic [XLEN-1:0] wb_res,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_A,
    output logic [XLEN-1:0] ex_B,
    output logic [3:0]      ex_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            load_use
);

    logic            r_valid;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic            r_use_imm;
    logic [3:0]      r_alu_ctrl;
    logic            r_reg_write;
    logic            r_mem_read;

    logic            w_load_use;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // MEM is the younger writer, so it takes precedence over WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      r,
        input logic [XLEN-1:0] v,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_res,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_res
    );
        logic [XLEN-1:0] sel;
        sel = v;
        if (r != 5'd0) begin
            if (m_we && (m_rd == r))
                sel = m_res;
            else if (w_we && (w_rd == r))
                sel = w_res;
        end
        return sel;
    endfunction

    always_comb begin
        w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
                     ((id_uses_rs1 && (id_rs1 == r_rd)) ||
                      (id_uses_rs2 && (id_rs2 == r_rd)));
        w_fwd_rs1  = fwd_sel(r_rs1, r_rs1_val, mem_reg_write, mem_rd, mem_res,
                             wb_reg_write, wb_rd, wb_res);
        w_fwd_rs2  = fwd_sel(r_rs2, r_rs2_val, mem_reg_write, mem_rd, mem_res,
                             wb_reg_write, wb_rd, wb_res);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush || (!stall && w_load_use)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (!stall) begin
            r_valid     <= id_valid;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_rs1_val   <= id_rs1_val;
            r_rs2_val   <= id_rs2_val;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_alu_ctrl  <= id_alu_ctrl;
            r_reg_write <= id_reg_write && id_valid;
            r_mem_read  <= id_mem_read && id_valid;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_A          = w_fwd_rs1;
    assign ex_B          = r_use_imm ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_ctrl       = r_alu_ctrl;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign load_use      = w_load_use;

endmodule

// File: tb/tb_id_ex_fwd.sv
// Scoreboard bench for id_ex_fwd: a stage-level reference model pushes the expected
// outputs for every cycle and a negedge monitor pops and compares them.
module tb_id_ex_fwd;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, id_use_imm, id_reg_write, id_mem_read;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm, mem_res, wb_res;
    logic [3:0]  id_alu_ctrl;
    logic        mem_reg_write, wb_reg_write;
    logic        ex_valid, ex_reg_write, ex_mem_read, load_use;
    logic [31:0] ex_A, ex_B, ex_store_data;
    logic [3:0]  ex_ctrl;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_fwd #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .mem_res(mem_res), .wb_res(wb_res),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_ctrl(ex_ctrl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .load_use(load_use)
    );

    // Instruction sitting in the model's EX stage; 'known' is 0 once fields are don't-care.
    typedef struct {
        bit        valid, known, use_imm, rw, mr;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] v1, v2, imm;
        bit [3:0]  ctrl;
    } ex_t;

    typedef struct {
        bit        full, valid, rw, mr, lu;
        bit [31:0] a, b, sd;
        bit [3:0]  ctrl;
        bit [4:0]  rd;
    } exp_t;

    ex_t  m;
    exp_t sb_q[$];
    bit   started = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Value a reader of register r sees: newest in-flight writer first, else the read value.
    function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] v);
        bit        we_l[$];
        bit [4:0]  rd_l[$];
        bit [31:0] res_l[$];
        we_l  = '{mem_reg_write, wb_reg_write};
        rd_l  = '{mem_rd, wb_rd};
        res_l = '{mem_res, wb_res};
        if (r == 0) return v;
        foreach (we_l[i])
            if (we_l[i] && rd_l[i] == r) return res_l[i];
        return v;
    endfunction

    task automatic step();
        exp_t e;
        ex_t  n;
        bit   dep;
        dep    = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        e.lu   = m.valid && m.mr && m.rd != 0 && id_valid && dep;
        e.full = m.known;
        e.valid = m.valid; e.rw = m.rw; e.mr = m.mr;
        e.a    = operand(m.rs1, m.v1);
        e.sd   = operand(m.rs2, m.v2);
        e.b    = m.use_imm ? m.imm : e.sd;
        e.ctrl = m.ctrl; e.rd = m.rd;
        if (started) sb_q.push_back(e);
        n = m;
        if (!rst_n) begin
            n = '{default: 0};
            n.known = 1;
        end else if (flush || (!stall && e.lu)) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.known = 0;
        end else if (!stall) begin
            n.valid = id_valid; n.known = 1;
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.v1 = id_rs1_val; n.v2 = id_rs2_val; n.imm = id_imm;
            n.use_imm = id_use_imm; n.ctrl = id_alu_ctrl;
            n.rw = id_valid && id_reg_write; n.mr = id_valid && id_mem_read;
        end
        @(posedge clk);
        #1;
        m = n;
        started = 1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
            chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
            chk("load_use", {31'd0, load_use}, {31'd0, e.lu});
            if (e.full) begin
                chk("ex_A", ex_A, e.a);
                chk("ex_B", ex_B, e.b);
                chk("ex_store_data", ex_store_data, e.sd);
                chk("ex_ctrl", {28'd0, ex_ctrl}, {28'd0, e.ctrl});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            end
        end
    end

    task automatic idle();
        rst_n = 1; stall = 0; flush = 0; id_valid = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_imm = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0; mem_res = 0; wb_res = 0;
    endtask

    task automatic instr(bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                         bit [31:0] v1, bit [31:0] v2, bit ld);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_val = v1; id_rs2_val = v2;
        id_alu_ctrl = 4'b0000; id_reg_write = 1; id_mem_read = ld;
    endtask

    task automatic randomize_id();
        id_valid = 1'($urandom); id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
        id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
        id_use_imm = 1'($urandom); id_alu_ctrl = 4'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    endtask

    initial begin
        m = '{default: 0};
        idle();
        // reset with arbitrary decode inputs
        randomize_id(); rst_n = 0;
        step(); randomize_id(); step();
        idle(); instr(5'd1, 5'd2, 5'd4, 32'd31, 32'd32, 0); step();
        idle(); step();
        // forwarding priority, EX frozen by stall
        instr(5'd5, 5'd6, 5'd7, 32'd1, 32'd2, 0); step();
        idle(); stall = 1;
        mem_rd = 5; mem_res = 100; mem_reg_write = 1;
        wb_rd = 5; wb_res = 200; wb_reg_write = 1; step();
        mem_reg_write = 0; step();
        stall = 0; instr(5'd0, 5'd0, 5'd8, 32'h55, 32'h66, 0);
        mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1; step();
        stall = 1; step();
        // immediate operand vs store data
        idle(); instr(5'd1, 5'd9, 5'd2, 32'd3, 32'd1, 0);
        id_use_imm = 1; id_imm = 32'hFFFF_FFFE; step();
        idle(); stall = 1; mem_rd = 9; mem_reg_write = 1; mem_res = 7; step();
        // load-use with and without a real dependency
        for (int k = 0; k < 2; k++) begin
            idle(); instr(5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 1); step();
            idle(); instr(5'd4, 5'd3, 5'd5, 32'd11, 32'd12, 0);
            id_uses_rs2 = (k == 0); id_uses_rs1 = 1; step();
            mem_rd = 3; mem_reg_write = 1; mem_res = 32'h1234; step();
            idle(); mem_rd = 3; mem_reg_write = 1; mem_res = 32'h1234; step();
        end
        // stall holds EX while decode changes
        idle(); instr(5'd1, 5'd2, 5'd6, 32'd77, 32'd88, 0); step();
        for (int k = 0; k < 3; k++) begin
            randomize_id(); stall = 1; step();
        end
        // flush beats stall
        flush = 1; step();
        idle(); step();
        // reset in the cycle load_use is raised
        instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1); step();
        idle(); instr(5'd3, 5'd0, 5'd4, 32'd5, 32'd6, 0); rst_n = 0; step();
        rst_n = 1; step();
        idle(); step();
        // random traffic over a tiny register window to provoke hazards
        for (int k = 0; k < 400; k++) begin
            randomize_id();
            rst_n = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
            mem_res = $urandom; wb_res = $urandom;
            step();
        end
        idle(); step();
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
